// File: rtl/btb_update_arbiter_if.sv
// Request lanes, control and BTB update bus between the producers and btb_update_arbiter.
interface btb_update_arbiter_if #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 16
);
  localparam int unsigned OCC_W = $clog2(DEPTH) + 1;

  logic             IN_brValid;
  logic [30:0]      IN_brSrc;
  logic [30:0]      IN_brDst;
  logic             IN_brIsJump;
  logic             IN_brCompr;
  logic             OUT_brReady;
  logic             IN_decValid;
  logic [30:0]      IN_decSrc;
  logic [30:0]      IN_decDst;
  logic             IN_decIsJump;
  logic             IN_decCompr;
  logic             OUT_decReady;
  logic             IN_stall;
  logic             IN_flush;
  logic [66:0]      OUT_btUpdate;
  logic [OCC_W-1:0] OUT_occupancy;
  logic [CNT_W-1:0] OUT_dupDrops;
  logic [CNT_W-1:0] OUT_fullDrops;

  modport master (
    output IN_brValid, IN_brSrc, IN_brDst, IN_brIsJump, IN_brCompr,
    output IN_decValid, IN_decSrc, IN_decDst, IN_decIsJump, IN_decCompr,
    output IN_stall, IN_flush,
    input  OUT_brReady, OUT_decReady, OUT_btUpdate, OUT_occupancy, OUT_dupDrops, OUT_fullDrops
  );

  modport slave (
    input  IN_brValid, IN_brSrc, IN_brDst, IN_brIsJump, IN_brCompr,
    input  IN_decValid, IN_decSrc, IN_decDst, IN_decIsJump, IN_decCompr,
    input  IN_stall, IN_flush,
    output OUT_brReady, OUT_decReady, OUT_btUpdate, OUT_occupancy, OUT_dupDrops, OUT_fullDrops
  );
endinterface

// File: rtl/btb_update_arbiter.sv
// Merges branch-unit and decode BTB update requests into a small FIFO with duplicate-src
// suppression, draining one registered BTB write per cycle.
module btb_update_arbiter #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 16
) (
  input logic                 clk,
  input logic                 rst,
  btb_update_arbiter_if.slave bus
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CW    = PTR_W + 1;
  localparam logic [CW-1:0] DepthC = CW'(DEPTH);

  logic [CW-1:0]    cnt_q, cnt_d;
  logic [PTR_W-1:0] head_q, tail_q, dec_slot;
  logic [30:0]      src_q [DEPTH];
  logic [30:0]      dst_q [DEPTH];
  logic [DEPTH-1:0] jump_q, compr_q, vld_q;
  logic [66:0]      upd_q;
  logic [CNT_W-1:0] dup_q, dup_d, full_q, full_d;
  logic [CNT_W:0]   dup_sum, full_sum;

  logic br_ready, dec_ready, br_hit, dec_hit;
  logic br_acc, dec_acc, br_dup, dec_dup, br_push, dec_push, pop;

  always_comb begin
    br_hit = 1'b0;
    dec_hit = 1'b0;
    // The entry being popped this cycle still has its valid flag set, so it is matched too.
    for (int i = 0; i < DEPTH; i++) begin
      if (vld_q[i] && src_q[i] == bus.IN_brSrc) br_hit = 1'b1;
      if (vld_q[i] && src_q[i] == bus.IN_decSrc) dec_hit = 1'b1;
    end
    br_ready  = !bus.IN_flush && cnt_q < DepthC;
    dec_ready = !bus.IN_flush && (cnt_q <= DepthC - CW'(2) ||
                                  (cnt_q == DepthC - CW'(1) && !bus.IN_brValid));
    br_acc   = bus.IN_brValid && br_ready;
    dec_acc  = bus.IN_decValid && dec_ready;
    br_dup   = br_acc && br_hit;
    dec_dup  = dec_acc && (dec_hit || (br_acc && bus.IN_brSrc == bus.IN_decSrc));
    br_push  = br_acc && !br_dup;
    dec_push = dec_acc && !dec_dup;
    pop      = !bus.IN_stall && !bus.IN_flush && cnt_q != '0;
    dec_slot = tail_q + PTR_W'(br_push);
    cnt_d    = cnt_q + CW'(br_push) + CW'(dec_push) - CW'(pop);
    dup_sum  = {1'b0, dup_q} + (CNT_W + 1)'(br_dup) + (CNT_W + 1)'(dec_dup);
    dup_d    = dup_sum[CNT_W] ? '1 : dup_sum[CNT_W-1:0];
    full_sum = {1'b0, full_q} + (CNT_W + 1)'(bus.IN_decValid && !dec_ready);
    full_d   = full_sum[CNT_W] ? '1 : full_sum[CNT_W-1:0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q  <= '0;
      head_q <= '0;
      tail_q <= '0;
      vld_q  <= '0;
      upd_q  <= '0;
      dup_q  <= '0;
      full_q <= '0;
    end else begin
      dup_q  <= dup_d;
      full_q <= full_d;
      if (bus.IN_flush) begin
        cnt_q    <= '0;
        head_q   <= '0;
        tail_q   <= '0;
        vld_q    <= '0;
        upd_q[0] <= 1'b0;
      end else begin
        if (pop) begin
          // Bit 3 and bit 35 of the update bus are unused and always written as zero.
          upd_q <= {src_q[head_q], 1'b0, dst_q[head_q], 1'b0, jump_q[head_q], compr_q[head_q],
                    1'b1};
          vld_q[head_q] <= 1'b0;
          head_q <= head_q + PTR_W'(1);
        end else begin
          upd_q[0] <= 1'b0;
        end
        if (br_push) vld_q[tail_q] <= 1'b1;
        if (dec_push) vld_q[dec_slot] <= 1'b1;
        tail_q <= tail_q + PTR_W'(br_push) + PTR_W'(dec_push);
        cnt_q  <= cnt_d;
      end
    end
  end

  // Payload storage needs no reset; entry validity is tracked by vld_q.
  always_ff @(posedge clk) begin
    if (br_push) begin
      src_q[tail_q]   <= bus.IN_brSrc;
      dst_q[tail_q]   <= bus.IN_brDst;
      jump_q[tail_q]  <= bus.IN_brIsJump;
      compr_q[tail_q] <= bus.IN_brCompr;
    end
    if (dec_push) begin
      src_q[dec_slot]   <= bus.IN_decSrc;
      dst_q[dec_slot]   <= bus.IN_decDst;
      jump_q[dec_slot]  <= bus.IN_decIsJump;
      compr_q[dec_slot] <= bus.IN_decCompr;
    end
  end

  assign bus.OUT_brReady   = br_ready;
  assign bus.OUT_decReady  = dec_ready;
  assign bus.OUT_btUpdate  = upd_q;
  assign bus.OUT_occupancy = cnt_q;
  assign bus.OUT_dupDrops  = dup_q;
  assign bus.OUT_fullDrops = full_q;
endmodule

// File: tb/tb_btb_update_arbiter.sv
// Directed bench for btb_update_arbiter with DEPTH=4, CNT_W=16.
module tb_btb_update_arbiter;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned CNT_W = 16;

  logic clk = 1'b0;
  logic rst;
  int n_cmp = 0;
  int n_bad = 0;
  int dup_exp = 0;
  int full_exp = 0;
  logic [66:0] exp_upd;

  always #5 clk = ~clk;

  btb_update_arbiter_if #(.DEPTH(DEPTH), .CNT_W(CNT_W)) bus ();

  btb_update_arbiter #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  function automatic logic [66:0] upd(input logic [30:0] s, input logic [30:0] d,
                                      input logic j, input logic c);
    return {s, 1'b0, d, 1'b0, j, c, 1'b1};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_br(input logic v, input logic [30:0] s, input logic [30:0] d,
                        input logic j, input logic c);
    bus.IN_brValid = v; bus.IN_brSrc = s; bus.IN_brDst = d;
    bus.IN_brIsJump = j; bus.IN_brCompr = c;
  endtask

  task automatic set_dec(input logic v, input logic [30:0] s, input logic [30:0] d,
                         input logic j, input logic c);
    bus.IN_decValid = v; bus.IN_decSrc = s; bus.IN_decDst = d;
    bus.IN_decIsJump = j; bus.IN_decCompr = c;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    set_br(0, 0, 0, 0, 0);
    set_dec(0, 0, 0, 0, 0);
    bus.IN_stall = 1'b0;
    bus.IN_flush = 1'b0;
    #1;
    n_cmp++;
    if (bus.OUT_btUpdate !== 67'd0) begin
      n_bad++; $display("FAIL reset_upd: got %h want 0", bus.OUT_btUpdate);
    end
    step(); step();
    rst = 1'b1;
    step();
    n_cmp++;
    if (bus.OUT_occupancy !== 3'd0) begin
      n_bad++; $display("FAIL reset_occ: got %0d want 0", bus.OUT_occupancy);
    end
    n_cmp++;
    if (bus.OUT_dupDrops !== 16'd0 || bus.OUT_fullDrops !== 16'd0) begin
      n_bad++; $display("FAIL reset_cnt: got %0d/%0d want 0/0", bus.OUT_dupDrops, bus.OUT_fullDrops);
    end
    n_cmp++;
    if (bus.OUT_brReady !== 1'b1 || bus.OUT_decReady !== 1'b1) begin
      n_bad++; $display("FAIL reset_ready: got %b%b want 11", bus.OUT_brReady, bus.OUT_decReady);
    end
  endtask

  task automatic test_single();
    set_br(1, 31'h100, 31'h2000, 1, 0);
    step();
    set_br(0, 0, 0, 0, 0);
    n_cmp++;
    if (bus.OUT_occupancy !== 3'd1 || bus.OUT_btUpdate[0] !== 1'b0) begin
      n_bad++; $display("FAIL single_queued: got occ %0d v %b want occ 1 v 0",
                        bus.OUT_occupancy, bus.OUT_btUpdate[0]);
    end
    step();
    exp_upd = upd(31'h100, 31'h2000, 1, 0);
    n_cmp++;
    if (bus.OUT_btUpdate !== exp_upd || bus.OUT_occupancy !== 3'd0) begin
      n_bad++; $display("FAIL single_out: got %h occ %0d want %h occ 0",
                        bus.OUT_btUpdate, bus.OUT_occupancy, exp_upd);
    end
    step();
    n_cmp++;
    if (bus.OUT_btUpdate !== {exp_upd[66:1], 1'b0}) begin
      n_bad++; $display("FAIL single_hold: got %h want %h", bus.OUT_btUpdate, {exp_upd[66:1], 1'b0});
    end
  endtask

  task automatic test_dup_same_cycle();
    bus.IN_stall = 1'b1;
    set_br(1, 31'h40, 31'h500, 0, 1);
    set_dec(1, 31'h40, 31'h600, 1, 0);
    step();
    dup_exp += 1;
    set_br(0, 0, 0, 0, 0);
    set_dec(0, 0, 0, 0, 0);
    n_cmp++;
    if (bus.OUT_occupancy !== 3'd1 || bus.OUT_dupDrops !== 16'(dup_exp)) begin
      n_bad++; $display("FAIL dup_same: got occ %0d dup %0d want occ 1 dup %0d",
                        bus.OUT_occupancy, bus.OUT_dupDrops, dup_exp);
    end
    bus.IN_stall = 1'b0;
    step();
    exp_upd = upd(31'h40, 31'h500, 0, 1);
    n_cmp++;
    if (bus.OUT_btUpdate !== exp_upd) begin
      n_bad++; $display("FAIL dup_same_out: got %h want %h", bus.OUT_btUpdate, exp_upd);
    end
    step();
    n_cmp++;
    if (bus.OUT_btUpdate[0] !== 1'b0 || bus.OUT_occupancy !== 3'd0) begin
      n_bad++; $display("FAIL dup_same_drain: got v %b occ %0d want v 0 occ 0",
                        bus.OUT_btUpdate[0], bus.OUT_occupancy);
    end
  endtask

  task automatic test_dup_queued();
    bus.IN_stall = 1'b1;
    set_br(1, 31'h80, 31'h880, 1, 1);
    step();
    set_br(0, 0, 0, 0, 0);
    set_dec(1, 31'h80, 31'h990, 0, 0);
    step();
    dup_exp += 1;
    n_cmp++;
    if (bus.OUT_occupancy !== 3'd1 || bus.OUT_dupDrops !== 16'(dup_exp)) begin
      n_bad++; $display("FAIL dup_queued: got occ %0d dup %0d want occ 1 dup %0d",
                        bus.OUT_occupancy, bus.OUT_dupDrops, dup_exp);
    end
    set_br(1, 31'h80, 31'h770, 0, 0);
    step();
    dup_exp += 2;
    set_br(0, 0, 0, 0, 0);
    n_cmp++;
    if (bus.OUT_occupancy !== 3'd1 || bus.OUT_dupDrops !== 16'(dup_exp)) begin
      n_bad++; $display("FAIL dup_both: got occ %0d dup %0d want occ 1 dup %0d",
                        bus.OUT_occupancy, bus.OUT_dupDrops, dup_exp);
    end
    // Decode request collides with the entry popped on the same edge.
    bus.IN_stall = 1'b0;
    step();
    dup_exp += 1;
    set_dec(0, 0, 0, 0, 0);
    exp_upd = upd(31'h80, 31'h880, 1, 1);
    n_cmp++;
    if (bus.OUT_btUpdate !== exp_upd || bus.OUT_occupancy !== 3'd0 ||
        bus.OUT_dupDrops !== 16'(dup_exp)) begin
      n_bad++; $display("FAIL dup_pop: got %h occ %0d dup %0d want %h occ 0 dup %0d",
                        bus.OUT_btUpdate, bus.OUT_occupancy, bus.OUT_dupDrops, exp_upd, dup_exp);
    end
    step();
    n_cmp++;
    if (bus.OUT_btUpdate[0] !== 1'b0) begin
      n_bad++; $display("FAIL dup_pop_drain: got v %b want 0", bus.OUT_btUpdate[0]);
    end
  endtask

  task automatic test_stall_fill();
    logic [66:0] order [4];
    bus.IN_stall = 1'b1;
    set_br(1, 31'h10, 31'h1010, 0, 0);
    set_dec(1, 31'h11, 31'h1011, 1, 1);
    #1;
    n_cmp++;
    if (bus.OUT_brReady !== 1'b1 || bus.OUT_decReady !== 1'b1) begin
      n_bad++; $display("FAIL fill_ready0: got %b%b want 11", bus.OUT_brReady, bus.OUT_decReady);
    end
    step();
    set_dec(0, 0, 0, 0, 0);
    set_br(1, 31'h12, 31'h1012, 0, 0);
    n_cmp++;
    if (bus.OUT_occupancy !== 3'd2) begin
      n_bad++; $display("FAIL fill_occ2: got %0d want 2", bus.OUT_occupancy);
    end
    step();
    set_br(1, 31'h13, 31'h1013, 1, 0);
    set_dec(1, 31'h14, 31'h1014, 0, 1);
    #1;
    n_cmp++;
    if (bus.OUT_occupancy !== 3'd3 || bus.OUT_brReady !== 1'b1 || bus.OUT_decReady !== 1'b0) begin
      n_bad++; $display("FAIL fill_cnt3: got occ %0d ready %b%b want occ 3 ready 10",
                        bus.OUT_occupancy, bus.OUT_brReady, bus.OUT_decReady);
    end
    step();
    full_exp += 1;
    set_br(0, 0, 0, 0, 0);
    n_cmp++;
    if (bus.OUT_occupancy !== 3'd4 || bus.OUT_brReady !== 1'b0 || bus.OUT_decReady !== 1'b0) begin
      n_bad++; $display("FAIL fill_full: got occ %0d ready %b%b want occ 4 ready 00",
                        bus.OUT_occupancy, bus.OUT_brReady, bus.OUT_decReady);
    end
    step();
    full_exp += 1;
    set_dec(0, 0, 0, 0, 0);
    n_cmp++;
    if (bus.OUT_fullDrops !== 16'(full_exp)) begin
      n_bad++; $display("FAIL fill_fulldrops: got %0d want %0d", bus.OUT_fullDrops, full_exp);
    end
    order[0] = upd(31'h10, 31'h1010, 0, 0);
    order[1] = upd(31'h11, 31'h1011, 1, 1);
    order[2] = upd(31'h12, 31'h1012, 0, 0);
    order[3] = upd(31'h13, 31'h1013, 1, 0);
    bus.IN_stall = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      n_cmp++;
      if (bus.OUT_btUpdate !== order[k] || bus.OUT_occupancy !== 3'(3 - k)) begin
        n_bad++; $display("FAIL fill_pop%0d: got %h occ %0d want %h occ %0d",
                          k, bus.OUT_btUpdate, bus.OUT_occupancy, order[k], 3 - k);
      end
    end
    step();
    n_cmp++;
    if (bus.OUT_btUpdate[0] !== 1'b0) begin
      n_bad++; $display("FAIL fill_drain: got v %b want 0", bus.OUT_btUpdate[0]);
    end
  endtask

  task automatic test_flush();
    bus.IN_stall = 1'b1;
    set_br(1, 31'h30, 31'h3030, 0, 0);
    set_dec(1, 31'h31, 31'h3031, 0, 0);
    step();
    set_dec(0, 0, 0, 0, 0);
    set_br(1, 31'h32, 31'h3032, 0, 0);
    step();
    n_cmp++;
    if (bus.OUT_occupancy !== 3'd3) begin
      n_bad++; $display("FAIL flush_pre: got occ %0d want 3", bus.OUT_occupancy);
    end
    bus.IN_flush = 1'b1;
    set_br(1, 31'h33, 31'h3033, 0, 0);
    set_dec(1, 31'h34, 31'h3034, 0, 0);
    #1;
    n_cmp++;
    if (bus.OUT_brReady !== 1'b0 || bus.OUT_decReady !== 1'b0) begin
      n_bad++; $display("FAIL flush_ready: got %b%b want 00", bus.OUT_brReady, bus.OUT_decReady);
    end
    step();
    full_exp += 1;
    bus.IN_flush = 1'b0;
    set_br(0, 0, 0, 0, 0);
    set_dec(0, 0, 0, 0, 0);
    n_cmp++;
    if (bus.OUT_occupancy !== 3'd0 || bus.OUT_btUpdate[0] !== 1'b0 ||
        bus.OUT_dupDrops !== 16'(dup_exp) || bus.OUT_fullDrops !== 16'(full_exp)) begin
      n_bad++; $display("FAIL flush_post: got occ %0d v %b dup %0d full %0d want 0 0 %0d %0d",
                        bus.OUT_occupancy, bus.OUT_btUpdate[0], bus.OUT_dupDrops,
                        bus.OUT_fullDrops, dup_exp, full_exp);
    end
    // A src that was flushed must not be treated as a duplicate.
    set_br(1, 31'h30, 31'h4040, 1, 0);
    step();
    set_br(0, 0, 0, 0, 0);
    n_cmp++;
    if (bus.OUT_occupancy !== 3'd1 || bus.OUT_dupDrops !== 16'(dup_exp)) begin
      n_bad++; $display("FAIL flush_nodup: got occ %0d dup %0d want occ 1 dup %0d",
                        bus.OUT_occupancy, bus.OUT_dupDrops, dup_exp);
    end
    bus.IN_stall = 1'b0;
    step();
    exp_upd = upd(31'h30, 31'h4040, 1, 0);
    n_cmp++;
    if (bus.OUT_btUpdate !== exp_upd) begin
      n_bad++; $display("FAIL flush_out: got %h want %h", bus.OUT_btUpdate, exp_upd);
    end
    step();
  endtask

  task automatic test_reset_mid();
    bus.IN_stall = 1'b1;
    set_br(1, 31'hA0, 31'hA0A0, 0, 0);
    step();
    bus.IN_stall = 1'b0;
    set_br(1, 31'hA1, 31'hA1A1, 0, 0);
    set_dec(1, 31'hA2, 31'hA2A2, 0, 0);
    step();
    set_br(0, 0, 0, 0, 0);
    set_dec(0, 0, 0, 0, 0);
    n_cmp++;
    if (bus.OUT_occupancy !== 3'd2 || bus.OUT_btUpdate[0] !== 1'b1) begin
      n_bad++; $display("FAIL rstmid_pre: got occ %0d v %b want occ 2 v 1",
                        bus.OUT_occupancy, bus.OUT_btUpdate[0]);
    end
    #2;
    rst = 1'b0;
    #1;
    n_cmp++;
    if (bus.OUT_btUpdate !== 67'd0 || bus.OUT_occupancy !== 3'd0 ||
        bus.OUT_dupDrops !== 16'd0 || bus.OUT_fullDrops !== 16'd0) begin
      n_bad++; $display("FAIL rstmid_async: got upd %h occ %0d dup %0d full %0d want all 0",
                        bus.OUT_btUpdate, bus.OUT_occupancy, bus.OUT_dupDrops, bus.OUT_fullDrops);
    end
    @(negedge clk);
    rst = 1'b1;
    step();
    n_cmp++;
    if (bus.OUT_occupancy !== 3'd0 || bus.OUT_btUpdate !== 67'd0) begin
      n_bad++; $display("FAIL rstmid_post: got occ %0d upd %h want occ 0 upd 0",
                        bus.OUT_occupancy, bus.OUT_btUpdate);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_dup_same_cycle();
    test_dup_queued();
    test_stall_fill();
    test_flush();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
